// File: rtl/free_list_pkg.sv
// sys_defs: shared rename-stage types and sizing for the R10K free list.
// Holds TAG, FL_STATE_T, id<->fl packets and derived widths.
package sys_defs;

  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int DEPTH  = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int PREG_W = $clog2(NUM_PHYS_REGS);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);

  typedef struct packed {
    logic [PREG_W-1:0] phys_reg;
    logic              valid;
    logic              ready;
  } TAG;

  typedef enum logic {
    FL_RUN,
    FL_RECOVER
  } FL_STATE_T;

  typedef struct packed {
    logic alloc_req;
  } ID_FL_PACKET;

  typedef struct packed {
    logic alloc_gnt;
    TAG   alloc_tag;
  } FL_ID_PACKET;

endpackage

// File: rtl/free_list_if.sv
// free_list_if: dispatch/retire bundle for the free list.
// master = rename/retire side, slave = free_list.
interface free_list_if;
  import sys_defs::*;

  logic             alloc_req;
  logic             alloc_gnt;
  TAG               alloc_tag;
  logic             retire_en;
  TAG               retire_t_old;
  logic             interrupt;
  logic [CNT_W-1:0] free_count;
  logic             empty;
  logic             overflow_err;

  modport master (
    output alloc_req, retire_en, retire_t_old, interrupt,
    input  alloc_gnt, alloc_tag, free_count, empty, overflow_err
  );

  modport slave (
    input  alloc_req, retire_en, retire_t_old, interrupt,
    output alloc_gnt, alloc_tag, free_count, empty, overflow_err
  );

endinterface

// File: rtl/free_list_ptr.sv
// fl_ptr: modulo-DEPTH pointer, inc enable plus synchronous load.
// Ports: clock, reset, inc, load, load_val -> ptr_q (state), ptr_d (next).
module fl_ptr #(
  parameter int DEPTH = 32,
  parameter int W     = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] ptr_q,
  output logic [W-1:0] ptr_d
);

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = (ptr_q == W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/free_list.sv
// free_list: circular FIFO of free phys regs; pop at dispatch, push T_old
// at retire, roll back on interrupt. Ports: clock, reset, fl (slave).
// Optional FREE_LIST_BYPASS_EN: retire->alloc forwarding when empty.
module free_list (
  input logic       clock,
  input logic       reset,
  free_list_if.slave fl
);
  import sys_defs::*;

  logic [PREG_W-1:0] fifo_q [DEPTH];
  logic [PREG_W-1:0] fifo_d [DEPTH];
  logic [CNT_W-1:0]  free_count_q, free_count_d;
  logic [CNT_W-1:0]  rcount_q, rcount_d;
  logic [CNT_W:0]    rsum;
  FL_STATE_T         state_q, state_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  rhead_q, rhead_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              run, empty, full;
  logic              pop, bypass, push, drop;
  logic              unused_tag_bits;

  assign unused_tag_bits = ^{fl.retire_t_old.valid,
                             fl.retire_t_old.ready};

  always_comb begin
    run   = (state_q == FL_RUN);
    empty = (free_count_q == '0);
    full  = (free_count_q == CNT_W'(DEPTH));
    pop   = fl.alloc_req & ~empty & run
          & ~fl.interrupt;
`ifdef FREE_LIST_BYPASS_EN
    bypass = empty & fl.retire_en & fl.alloc_req
           & run & ~fl.interrupt;
`else
    bypass = 1'b0;
`endif
    // a full list still accepts a push if a pop frees a slot
    drop = fl.retire_en & full & ~pop;
    push = fl.retire_en & ~drop & ~bypass;
  end

  fl_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_rhead (
    .clock(clock), .reset(reset),
    .inc(fl.retire_en), .load(1'b0), .load_val('0),
    .ptr_q(rhead_q), .ptr_d(rhead_d)
  );

  // squash rolls the speculative head back to the retired point
  fl_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_head (
    .clock(clock), .reset(reset),
    .inc(pop), .load(fl.interrupt), .load_val(rhead_d),
    .ptr_q(head_q), .ptr_d(head_d)
  );

  fl_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_tail (
    .clock(clock), .reset(reset),
    .inc(push), .load(1'b0), .load_val('0),
    .ptr_q(tail_q), .ptr_d(tail_d)
  );

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[tail_q] = fl.retire_t_old.phys_reg;
  end

  // each retire frees one reg and commits one, so the
  // retired-point free count never moves
  always_comb begin
    rcount_d = rcount_q;
    rsum = {1'b0, rcount_q}
         + (CNT_W+1)'(fl.retire_en);
  end

  always_comb begin
    free_count_d = free_count_q;
    if (fl.interrupt) begin
      free_count_d = (rsum > (CNT_W+1)'(DEPTH))
                   ? CNT_W'(DEPTH) : rsum[CNT_W-1:0];
    end else if (pop & ~push) begin
      free_count_d = free_count_q - 1'b1;
    end else if (push & ~pop) begin
      free_count_d = free_count_q + 1'b1;
    end
  end

  always_comb begin
    state_d = fl.interrupt ? FL_RECOVER : FL_RUN;
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        fifo_q[i] <= PREG_W'(NUM_ARCH_REGS + i);
      free_count_q <= CNT_W'(DEPTH);
      rcount_q     <= CNT_W'(DEPTH);
      state_q      <= FL_RUN;
      ovf_q        <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      free_count_q <= free_count_d;
      rcount_q     <= rcount_d;
      state_q      <= state_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    fl.alloc_gnt          = (pop | bypass) & ~reset;
    fl.alloc_tag.phys_reg = bypass
                          ? fl.retire_t_old.phys_reg
                          : fifo_q[head_q];
    fl.alloc_tag.valid    = 1'b1;
    fl.alloc_tag.ready    = 1'b0;
    fl.free_count         = free_count_q;
    fl.empty              = empty;
    fl.overflow_err       = ovf_q;
  end

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed vectors for free_list with hand-computed results.
// Inputs change just after negedge; outputs sampled 1ns later.
module tb_free_list;
  import sys_defs::*;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  free_list_if fl();

  free_list dut (
    .clock(clock),
    .reset(reset),
    .fl(fl)
  );

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic drive(logic req, logic ret, int told, logic intr);
    @(negedge clock);
    fl.alloc_req             = req;
    fl.retire_en             = ret;
    fl.retire_t_old.phys_reg = PREG_W'(told);
    fl.retire_t_old.valid    = 1'b1;
    fl.retire_t_old.ready    = 1'b0;
    fl.interrupt             = intr;
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (2) drive(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    fl.alloc_req = 1'b1;
    fl.retire_en = 1'b0;
    fl.retire_t_old = '0;
    fl.interrupt = 1'b0;
    #12;
    check("rst_cnt", fl.free_count, 32);
    check("rst_empty", fl.empty, 0);
    check("rst_ovf", fl.overflow_err, 0);
    check("rst_gnt", fl.alloc_gnt, 0);

    // T1: drain all 32 free regs in order
    do_reset;
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0);
      check("t1_gnt", fl.alloc_gnt, 1);
      check("t1_tag", fl.alloc_tag.phys_reg, 32 + i);
      if (i == 0) begin
        check("t1_valid", fl.alloc_tag.valid, 1);
        check("t1_ready", fl.alloc_tag.ready, 0);
      end
    end
    drive(1, 0, 0, 0);
    check("t1_gnt_empty", fl.alloc_gnt, 0);
    check("t1_empty", fl.empty, 1);
    check("t1_cnt", fl.free_count, 0);

    // T2: alloc 3, retire p1..p3, then wrap
    do_reset;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      check("t2_tag_a", fl.alloc_tag.phys_reg, 32 + i);
    end
    for (int k = 1; k <= 3; k++) drive(0, 1, k, 0);
    drive(0, 0, 0, 0);
    check("t2_cnt", fl.free_count, 32);
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0);
      check("t2_gnt", fl.alloc_gnt, 1);
      check("t2_tag", fl.alloc_tag.phys_reg,
            (i < 29) ? 35 + i : i - 28);
    end
    drive(0, 0, 0, 0);
    check("t2_cnt_end", fl.free_count, 0);

    // T3: alloc 5, retire 2, interrupt, recover
    do_reset;
    repeat (5) drive(1, 0, 0, 0);
    drive(0, 1, 5, 0);
    drive(0, 1, 6, 0);
    check("t3_cnt_pre", fl.free_count, 28);
    drive(1, 0, 0, 1);
    check("t3_int_gnt", fl.alloc_gnt, 0);
    drive(1, 0, 0, 0);
    check("t3_recover", fl.alloc_gnt, 0);
    check("t3_cnt", fl.free_count, 32);
    drive(1, 0, 0, 0);
    check("t3_gnt", fl.alloc_gnt, 1);
    check("t3_tag", fl.alloc_tag.phys_reg, 34);

    // T4: simultaneous alloc and free at count 10
    do_reset;
    repeat (22) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("t4_cnt_pre", fl.free_count, 10);
    drive(1, 1, 9, 0);
    check("t4_gnt", fl.alloc_gnt, 1);
    check("t4_tag", fl.alloc_tag.phys_reg, 54);
    drive(0, 0, 0, 0);
    check("t4_cnt", fl.free_count, 10);

    // T5: empty with same-cycle retire
    do_reset;
    repeat (32) drive(1, 0, 0, 0);
    drive(1, 1, 7, 0);
`ifdef FREE_LIST_BYPASS_EN
    check("t5_gnt", fl.alloc_gnt, 1);
    check("t5_tag", fl.alloc_tag.phys_reg, 7);
    drive(0, 0, 0, 0);
    check("t5_cnt", fl.free_count, 0);
`else
    check("t5_gnt", fl.alloc_gnt, 0);
    drive(0, 0, 0, 0);
    check("t5_cnt", fl.free_count, 1);
    check("t5_empty", fl.empty, 0);
    drive(1, 0, 0, 0);
    check("t5_gnt_next", fl.alloc_gnt, 1);
    check("t5_tag_next", fl.alloc_tag.phys_reg, 7);
`endif

    // T6: overflow when full, then async reset mid-run
    do_reset;
    drive(0, 1, 1, 0);
    drive(0, 0, 0, 0);
    check("t6_ovf", fl.overflow_err, 1);
    check("t6_cnt", fl.free_count, 32);
    drive(1, 0, 0, 0);
    check("t6_tag0", fl.alloc_tag.phys_reg, 32);
    drive(1, 0, 0, 0);
    check("t6_tag1", fl.alloc_tag.phys_reg, 33);
    drive(1, 0, 0, 0);
    check("t6_cnt_run", fl.free_count, 30);
    check("t6_ovf_sticky", fl.overflow_err, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_cnt", fl.free_count, 32);
    check("t6_rst_ovf", fl.overflow_err, 0);
    check("t6_rst_empty", fl.empty, 0);
    check("t6_rst_gnt", fl.alloc_gnt, 0);
    drive(0, 0, 0, 0);
    reset = 1'b0;
    drive(1, 0, 0, 0);
    check("t6_post_gnt", fl.alloc_gnt, 1);
    check("t6_post_tag", fl.alloc_tag.phys_reg, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
